// File: rtl/instr_mem_stream.sv
// instr_mem_stream
//   Pipelined instruction memory between the fetch unit and decode.
//   Requests and responses use valid/ready handshakes, and responses always
//   return in order.
//   A request is read through a LATENCY-deep shift pipeline and then lands
//   in an output FIFO of depth LATENCY+2.
//   A credit counter limits the requests in flight (pipeline plus FIFO) to
//   the FIFO depth, so the pipeline never has to stall and the FIFO can
//   never overflow.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pipeline, FIFO and credits
//   req_valid  fetch request valid
//   req_ready  request may be accepted (depends only on registered state and reset)
//   req_addr   byte address of the instruction
//   flush      discard everything in flight; a same-cycle request is kept
//   rsp_valid  response valid (FIFO not empty)
//   rsp_ready  decode accepts the response
//   rsp_instr  fetched instruction, or NOP for a faulting fetch
//   rsp_addr   echo of the request address
//   rsp_fault  bit0 = misaligned, bit1 = out of range
//
// Optional feature (macro IMEM_LOAD_PORT_EN)
//   ld_en/ld_addr/ld_data write one word at the rising edge.
//   Misaligned or out-of-range loads are ignored.
//   A same-cycle read of the same word sees the old data.
//   Without the macro, the array is read-only after the INIT_FILE load.
module instr_mem_stream #(
    parameter int    DEPTH     = 1024,
    parameter int    AW        = 32,
    parameter int    IW        = 32,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = "program.mem"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [IW-1:0] rsp_instr,
    output logic [AW-1:0] rsp_addr,
    output logic [1:0]    rsp_fault
`ifdef IMEM_LOAD_PORT_EN
    ,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data
`endif
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int FD   = LATENCY + 2;
    localparam int CW   = $clog2(LATENCY + 3);
    localparam int PW   = $clog2(FD);
    // Address bits above the word index; if any of them is set, the address is out of range.
    localparam logic [AW-1:0] HI_MASK = ~((AW'(1) << (IDXW + 2)) - AW'(1));
    localparam logic [IW-1:0] NOP     = IW'(32'h00000013);

    logic [IW-1:0]   mem [DEPTH];

    logic            accept;
    logic            consume;
    logic            push;
    logic [1:0]      req_fault;
    logic [IDXW-1:0] req_idx;
    logic [CW-1:0]   outstanding;

    logic [LATENCY-1:0] pv;
    logic [AW-1:0]      pa [LATENCY];
    logic [1:0]         pf [LATENCY];
    logic [IW-1:0]      pd [LATENCY];

    logic [IW-1:0] fi [FD];
    logic [AW-1:0] fa [FD];
    logic [1:0]    ff [FD];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] fcnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_idx   = req_addr[IDXW+1:2];
    assign req_fault = {|(req_addr & HI_MASK), |req_addr[1:0]};
    // Gating with reset keeps ready low for the whole reset window.
    // Once reset drops, ready rises straight away.
    assign req_ready = !reset && (outstanding < CW'(FD));
    assign accept    = req_valid && req_ready;
    assign consume   = rsp_valid && rsp_ready;
    assign push      = pv[LATENCY-1] && !flush;

    assign rsp_valid = (fcnt != '0);
    assign rsp_instr = fi[rp];
    assign rsp_addr  = fa[rp];
    assign rsp_fault = ff[rp];

`ifdef IMEM_LOAD_PORT_EN
    logic ld_ok;
    assign ld_ok = ld_en && (ld_addr[1:0] == 2'b00) && ((ld_addr & HI_MASK) == '0);
`endif

    // Array access and the data side of the read pipeline.
    // None of this is reset: the array keeps its contents, and the payload
    // registers only matter when the matching valid bit is set.
    // A faulting request skips the array and carries a NOP forward instead.
    // A same-cycle load to the same word cannot be seen by the read, because
    // the read samples the array before the write lands.
    always_ff @(posedge clk) begin
`ifdef IMEM_LOAD_PORT_EN
        if (ld_ok) begin
            mem[ld_addr[IDXW+1:2]] <= ld_data;
        end
`endif
        if (accept) begin
            pa[0] <= req_addr;
            pf[0] <= req_fault;
            if (req_fault == 2'b00) begin
                pd[0] <= mem[req_idx];
            end else begin
                pd[0] <= NOP;
            end
        end
        for (int s = 1; s < LATENCY; s++) begin
            pa[s] <= pa[s-1];
            pf[s] <= pf[s-1];
            pd[s] <= pd[s-1];
        end
    end

    // Valid bits of the read pipeline. On flush or reset, every older entry
    // is discarded. A request accepted in the flush cycle still enters
    // stage 0, because it belongs to the redirected stream.
    always_ff @(posedge clk) begin
        pv[0] <= accept;
        for (int s = 1; s < LATENCY; s++) begin
            pv[s] <= (reset || flush) ? 1'b0 : pv[s-1];
        end
    end

    // Output FIFO. Its head drives the response outputs directly, so the
    // payload holds steady while decode stalls. Reset also clears the
    // storage, so the response outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
            for (int i = 0; i < FD; i++) begin
                fi[i] <= '0;
                fa[i] <= '0;
                ff[i] <= '0;
            end
        end else if (flush) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (push) begin
                fi[wp] <= pd[LATENCY-1];
                fa[wp] <= pa[LATENCY-1];
                ff[wp] <= pf[LATENCY-1];
                wp     <= ptr_inc(wp);
            end
            if (consume) begin
                rp <= ptr_inc(rp);
            end
            fcnt <= fcnt + CW'(push) - CW'(consume);
        end
    end

    // Credit counter: the number of requests in the pipeline plus the FIFO.
    // After a flush, only the request accepted in that same cycle is still
    // in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else if (flush) begin
            outstanding <= CW'(accept);
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(consume);
        end
    end

endmodule

// File: tb/tb_instr_mem_stream.sv
// tb_instr_mem_stream
//   Self-checking bench for instr_mem_stream, built with LATENCY=3 and DEPTH=1024.
//   The reference model is a queue of expected responses. Each entry
//   carries the cycle at which it becomes visible, so the model follows the
//   rules directly: a response is visible LATENCY edges after acceptance,
//   responses leave in order, credits equal the queue length, and flush or
//   reset empties the queue.
module tb_instr_mem_stream;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int LAT   = 3;
    localparam int CAP   = LAT + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          flush;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IW-1:0] rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic [1:0]    rsp_fault;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
        int          rdy;
    } entry_t;

    entry_t      q[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    bit          m_valid;
    bit          m_ready;
    bit          last_reset = 1'b0;

    always #5 clk = ~clk;

    instr_mem_stream #(
        .DEPTH(DEPTH), .AW(AW), .IW(IW), .LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr),
        .rsp_fault(rsp_fault)
`ifdef IMEM_LOAD_PORT_EN
        ,
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit rv, input logic [31:0] a, input bit rr,
                                 input bit fl, input bit rs);
        req_valid = rv;
        req_addr  = a;
        rsp_ready = rr;
        flush     = fl;
        reset     = rs;
    endtask

    task automatic loadStimulus(input bit en, input logic [31:0] a, input logic [31:0] d);
        ld_en   = en;
        ld_addr = a;
        ld_data = d;
    endtask

    // Expected response for a request, from the address rules alone.
    function automatic entry_t makeEntry(input logic [31:0] a, input int rdy);
        entry_t e;
        bit mis;
        bit oor;
        mis     = (a % 4) != 0;
        oor     = a >= 32'(DEPTH * 4);
        e.addr  = a;
        e.fault = {oor, mis};
        e.instr = (mis || oor) ? 32'h00000013 : model_mem[a / 4];
        e.rdy   = rdy;
        return e;
    endfunction

    task automatic modelEdge();
        last_reset = reset;
        if (reset) begin
            q.delete();
        end else begin
            if (m_valid && rsp_ready) void'(q.pop_front());
            if (flush) q.delete();
            if (req_valid && m_ready) q.push_back(makeEntry(req_addr, cyc + LAT));
        end
`ifdef IMEM_LOAD_PORT_EN
        if (ld_en && (ld_addr % 4) == 0 && ld_addr < 32'(DEPTH * 4))
            model_mem[ld_addr / 4] = ld_data;
`endif
    endtask

    // One clock cycle: check at the falling edge, then advance the model at
    // the rising edge. The current inputs are held until the next
    // applyStimulus call.
    task automatic tick();
        @(negedge clk);
        m_ready = !reset && (q.size() < CAP);
        m_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        checkOutput("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
        checkOutput("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
        if (m_valid) begin
            checkOutput("rsp_instr", 64'(rsp_instr), 64'(q[0].instr));
            checkOutput("rsp_addr", 64'(rsp_addr), 64'(q[0].addr));
            checkOutput("rsp_fault", 64'(rsp_fault), 64'(q[0].fault));
        end
        if (last_reset) begin
            checkOutput("reset_instr", 64'(rsp_instr), 64'd0);
            checkOutput("reset_addr", 64'(rsp_addr), 64'd0);
            checkOutput("reset_fault", 64'(rsp_fault), 64'd0);
        end
        if (req_valid === 1'b1 && req_ready === 1'b1) acc_cnt++;
        @(posedge clk);
        cyc++;
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 32'h0, rr, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        loadStimulus(1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = $urandom;
`ifndef IMEM_LOAD_PORT_EN
        for (int i = 0; i < DEPTH; i++) dut.mem[i] = model_mem[i];
`endif

        // Reset: ready low while held, high in the first cycle after it drops.
        for (int i = 0; i < 3; i++) tick();
`ifdef IMEM_LOAD_PORT_EN
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            loadStimulus(1'b1, 32'(i * 4), model_mem[i]);
            tick();
        end
        loadStimulus(1'b0, 32'h0, 32'h0);
        tick();
`endif
        idle(1, 1'b1);

        // Back-to-back fetches with decode always ready.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle(6, 1'b1);

        // Decode stalled: only CAP requests may be accepted.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(32'h200 + i * 4), 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("stall_accepts", 64'(acc_cnt), 64'(CAP));
        idle(10, 1'b1);

        // Faults: misaligned, out of range, last valid word, both faults.
        applyStimulus(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);          tick();
        applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0);       tick();
        applyStimulus(1'b1, 32'hFFC, 1'b1, 1'b0, 1'b0);        tick();
        applyStimulus(1'b1, 32'h8000_0003, 1'b1, 1'b0, 1'b0);  tick();
        idle(6, 1'b1);

        // Flush with three in flight and a concurrent request to 0x40.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(32'h100 + i * 4), 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        tick();
        idle(8, 1'b1);

        // Reset while responses are buffered.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(32'h300 + i * 4), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(4, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        idle(3, 1'b1);

`ifdef IMEM_LOAD_PORT_EN
        // Load, then fetch. Then load and fetch the same word in one cycle.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        loadStimulus(1'b1, 32'h20, 32'hDEADBEEF);
        tick();
        loadStimulus(1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
        loadStimulus(1'b1, 32'h24, 32'hCAFEF00D);
        tick();
        loadStimulus(1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
        tick();
        idle(6, 1'b1);
`endif

        // Randomized traffic with occasional faults, flushes and resets.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            int sel;
            a   = 32'($urandom_range(0, DEPTH - 1)) * 4;
            sel = $urandom_range(0, 99);
            if (sel < 8) a = a + 32'($urandom_range(1, 3));
            else if (sel < 13) a = a | (32'h1 << $urandom_range(12, 31));
            applyStimulus($urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 1);
`ifdef IMEM_LOAD_PORT_EN
            loadStimulus($urandom_range(0, 99) < 10,
                         32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 99) < 10),
                         $urandom);
`endif
            tick();
        end
        loadStimulus(1'b0, 32'h0, 32'h0);
        idle(10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_stream.md
Name: instr_mem_stream

Overview:
- Parametrised, pipelined instruction memory with valid/ready request and response channels. Successor to the single-cycle fetch memory.
- Sits between the fetch unit and the decode stage. Supports configurable read latency, back-pressure from decode, flush on branch redirect, and fault reporting for misaligned or out-of-range fetches.
- Responses always return in order.

Parameters:
- DEPTH, 1024: number of instruction words; power of two, 16..65536.
- AW, 32: request address width (byte address).
- IW, 32: instruction width.
- LATENCY, 1: read pipeline stages, 1..4.
- INIT_FILE, "program.mem": hex image loaded into the array at elaboration.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request may be accepted.
- req_addr  in  AW  byte address of the instruction.
- flush  in  1  discard all in-flight and buffered responses.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  decode accepts the response.
- rsp_instr  out  IW  fetched instruction.
- rsp_addr  out  AW  echo of the request address.
- rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.

Behaviour:
- **Handshakes**
  - A request is accepted when req_valid && req_ready at a rising edge.
  - A response is consumed when rsp_valid && rsp_ready.
- **Word index and faults**
  - Word index = req_addr[log2(DEPTH)+1:2].
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: any req_addr bit above log2(DEPTH)+1 is set.
  - A faulting request returns rsp_instr = 32'h00000013 (NOP), the fault bits set, and makes no array access.
- **Latency and buffering**
  - A request accepted at edge k appears with rsp_valid=1 after edge k+LATENCY, provided the output buffer is empty.
  - Read data passes through a LATENCY-deep shift pipeline (valid, addr, fault, data) into an output FIFO of depth LATENCY+2.
  - The FIFO head drives the rsp_* outputs directly.
  - rsp_valid = FIFO not empty. The payload holds stable while rsp_valid && !rsp_ready.
- **Credit counter**
  - outstanding = pipeline entries + FIFO entries.
  - Increments on accept, decrements on consume, and is unchanged when both occur in the same cycle.
  - req_ready = (outstanding < LATENCY+2). It is a registered function only, with no combinational path from rsp_ready.
  - With rsp_ready held high, throughput is sustained at 1 request per cycle.
  - FIFO overflow is impossible by construction.
- **Flush**
  - At the edge where flush=1, all pipeline valids and the FIFO are cleared, and outstanding is set to 0.
  - A request accepted in the same cycle as flush is kept: it enters the pipeline, and outstanding becomes 1.
  - A response presented in the flush cycle counts as consumed only if rsp_ready=1; either way it is dropped.
  - rsp_valid=0 in the cycle after flush.
- **Reset**
  - rsp_valid=0, outstanding=0, FIFO empty, pipeline valids cleared.
  - rsp_instr, rsp_addr and rsp_fault are 0.
  - req_ready=0 while reset=1 and 1 in the first cycle after reset.
  - Reset mid-operation discards everything, like flush.
  - Array contents are not reset.
- **Wrap-around**: FIFO pointers wrap modulo LATENCY+2; the credit counter width is clog2(LATENCY+3).

Optional Feature:
- Macro: IMEM_LOAD_PORT_EN.
- Enabled, three input ports are added:
  - ld_en (1): write strobe.
  - ld_addr (AW): byte address.
  - ld_data (IW): write data.
- On ld_en, mem[ld_addr word index] is written at the rising edge. Misaligned or out-of-range loads are ignored.
- A read of the same word in the same cycle returns the old data.
- Disabled: the ports are absent and the array is read-only after INIT_FILE load.

Test Plan:
- Reset, then LATENCY=1 with req_addr=0x0,0x4,0x8 on consecutive cycles and rsp_ready=1 -> rsp_valid on cycles 1,2,3 after acceptance, with mem[0..2] in order and rsp_fault=0.
- LATENCY=3 with rsp_ready=0 and requests streamed -> exactly 5 accepted, then req_ready=0. Raising rsp_ready drains all 5 in order, with no loss or duplication.
- req_addr=0x6 -> rsp_instr=0x00000013, rsp_fault=2'b01. req_addr=0x1000 (DEPTH=1024) -> rsp_fault=2'b10.
- 3 requests outstanding, then flush=1 with a concurrent request to 0x40 -> the 3 responses are never presented, and the next rsp is mem[0x10] with rsp_addr=0x40.
- reset asserted with responses buffered -> next cycle rsp_valid=0 and req_ready=0. After deassertion req_ready=1 and outstanding=0.
- IMEM_LOAD_PORT_EN: write 0xDEADBEEF to 0x20, then fetch 0x20 -> rsp_instr=0xDEADBEEF. A same-cycle write and read of 0x24 returns the old word.
